// File: rtl/cam_capture_ctrl.sv
// Camera frame capture sequencer: arms on start, aligns to vsync, drives frame buffer writes.
// Optional per-line pixel count check when LINE_CHECK_EN is defined.
module cam_capture_ctrl #(
    parameter int H_PIX = 160,
    parameter int V_PIX = 120,
    parameter int AW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          continuous,
    input  logic          stop,
    input  logic          cam_vsync,
    input  logic          cam_href,
    input  logic          px_valid,
    input  logic [11:0]   px_data,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [11:0]   mem_data,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    // One extra bit so the pixel count can reach a full frame even when it equals 2**AW.
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] FRAME_PIX = CW'(H_PIX * V_PIX);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_VS = 3'd1,
        ST_WAIT_FR = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            vs_d_r;
    logic            cont_q_r;
    logic [CW-1:0]   count_r;
    logic            mem_wr_r;
    logic [AW-1:0]   mem_addr_r;
    logic [11:0]     mem_data_r;
    logic            busy_r;
    logic            frame_done_r;
    logic            err_r;

    logic            vs_rise_s;
    logic            vs_fall_s;
    logic            accept_s;
    logic            arm_s;
    logic            frame_start_s;
    logic            wr_s;
    logic            ovf_s;
    logic            short_s;
    logic            line_err_s;

    assign vs_rise_s = cam_vsync & ~vs_d_r;
    assign vs_fall_s = ~cam_vsync & vs_d_r;
    assign accept_s  = px_valid & cam_href;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode and per-cycle write/error strobes
    always_comb begin
        state_nxt_s   = state_r;
        arm_s         = 1'b0;
        frame_start_s = 1'b0;
        wr_s          = 1'b0;
        ovf_s         = 1'b0;
        short_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_WAIT_VS;
                    arm_s       = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_VS: begin
                // Only a blanking interval guarantees we never join a frame halfway.
                if (cam_vsync) begin
                    state_nxt_s = ST_WAIT_FR;
                end else begin
                    state_nxt_s = ST_WAIT_VS;
                end
            end
            ST_WAIT_FR: begin
                if (vs_fall_s) begin
                    state_nxt_s   = ST_CAPTURE;
                    frame_start_s = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT_FR;
                end
            end
            ST_CAPTURE: begin
                if (accept_s && (count_r < FRAME_PIX)) begin
                    wr_s = 1'b1;
                end else if (accept_s) begin
                    ovf_s = 1'b1;
                end else begin
                    wr_s = 1'b0;
                end
                if (vs_rise_s) begin
                    state_nxt_s = ST_DONE;
                    short_s     = ((count_r + CW'(wr_s)) < FRAME_PIX);
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DONE: begin
                if (cont_q_r && !stop) begin
                    state_nxt_s = ST_WAIT_FR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pixel counter, buffer write port, mode latch and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d_r       <= 1'b0;
            cont_q_r     <= 1'b0;
            count_r      <= {CW{1'b0}};
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            mem_data_r   <= 12'h000;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            vs_d_r       <= cam_vsync;
            mem_wr_r     <= wr_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            frame_done_r <= (state_nxt_s == ST_DONE);
            // Address shows the slot being written; it holds after the last write of a frame.
            if (wr_s) begin
                mem_addr_r <= count_r[AW-1:0];
                mem_data_r <= px_data;
                count_r    <= count_r + CW'(1'b1);
            end else if (arm_s || frame_start_s) begin
                mem_addr_r <= {AW{1'b0}};
                count_r    <= {CW{1'b0}};
            end
            if (arm_s) begin
                cont_q_r <= continuous & ~stop;
            end else if (stop) begin
                cont_q_r <= 1'b0;
            end
            if (arm_s) begin
                err_r <= 1'b0;
            end else if (ovf_s || short_s || line_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

`ifdef LINE_CHECK_EN
    localparam int LW = $clog2(H_PIX + 1) + 1;

    logic          href_d_r;
    logic [LW-1:0] line_cnt_r;

    // Per-line pixel count, restarted on every href rise; saturates on runaway lines
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            href_d_r   <= 1'b0;
            line_cnt_r <= {LW{1'b0}};
        end else begin
            href_d_r <= cam_href;
            if (cam_href && !href_d_r) begin
                line_cnt_r <= accept_s ? LW'(1'b1) : {LW{1'b0}};
            end else if (accept_s && (line_cnt_r != {LW{1'b1}})) begin
                line_cnt_r <= line_cnt_r + LW'(1'b1);
            end
        end
    end

    assign line_err_s = (state_r == ST_CAPTURE) && href_d_r && !cam_href &&
                        (line_cnt_r != LW'(H_PIX));
`else
    assign line_err_s = 1'b0;
`endif

    assign mem_wr     = mem_wr_r;
    assign mem_addr   = mem_addr_r;
    assign mem_data   = mem_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl on a reduced 16x8 frame (2**AW equals frame size).
`timescale 1ns/1ps
module tb_cam_capture_ctrl;

    localparam int H  = 16;
    localparam int V  = 8;
    localparam int AW = 7;
    localparam int FR = H * V;
`ifdef LINE_CHECK_EN
    localparam bit LINE_CHECK = 1'b1;
`else
    localparam bit LINE_CHECK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          continuous;
    logic          stop;
    logic          cam_vsync;
    logic          cam_href;
    logic          px_valid;
    logic [11:0]   px_data;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [11:0]   mem_data;
    logic          busy;
    logic          frame_done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int fd_cnt = 0;

    // Observed writes and the reference stream of pixels offered with href high.
    logic [AW-1:0] wr_addr_q[$];
    logic [11:0]   wr_data_q[$];
    int            wr_cyc_q[$];
    logic [11:0]   sent_q[$];
    int            sent_cyc_q[$];

    cam_capture_ctrl #(.H_PIX(H), .V_PIX(V), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .stop(stop),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .px_valid(px_valid), .px_data(px_data),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input bit cont);
        start = 1'b1;
        continuous = cont;
        tick();
        start = 1'b0;
        continuous = 1'b0;
    endtask

    // One active line of len pixels with random gaps, then a short blank with a stray strobe.
    task automatic drive_line(input int len, input bit rec);
        int sent = 0;
        cam_href = 1'b1;
        while (sent < len) begin
            if ($urandom_range(0, 3) != 0) begin
                px_valid = 1'b1;
                px_data  = 12'($urandom);
                if (rec) begin
                    sent_q.push_back(px_data);
                    sent_cyc_q.push_back(cyc + 1);
                end
                sent++;
            end else begin
                px_valid = 1'b0;
            end
            tick();
            stop = 1'b0;
        end
        cam_href = 1'b0;
        px_valid = 1'b1;
        px_data  = 12'($urandom);
        tick();
        px_valid = 1'b0;
        tick();
    endtask

    task automatic drive_frame(input int nlines, input int bad_line, input int bad_len,
                               input int extra, input int stop_at, input bit rec);
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < nlines; l++) begin
            int len;
            len = (l == bad_line) ? bad_len : H;
            if (l == nlines - 1) len += extra;
            if (l == stop_at) stop = 1'b1;
            drive_line(len, rec);
        end
        cam_vsync = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        int wb;
        int fb;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; stop = 1'b0;
        cam_vsync = 1'b0; cam_href = 1'b0; px_valid = 1'b0; px_data = 12'h000;
        repeat (3) tick();
        n_cmp++;
        if ({mem_wr, mem_addr, mem_data, busy, frame_done, err} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_values: got %h expected 0", {mem_wr, mem_addr, mem_data, busy, frame_done, err});
        end
        rst = 1'b0;
        tick();
        arm(1'b1);
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        drive_line(H, 1'b0);
        n_cmp++;
        if (busy !== 1'b1 || mem_addr !== AW'(H - 1)) begin
            n_bad++;
            $display("FAIL reset_prestate: busy=%b addr=%0d expected busy=1 addr=%0d", busy, mem_addr, H - 1);
        end
        cam_href = 1'b1; px_valid = 1'b1; px_data = 12'($urandom);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({mem_wr, mem_addr, mem_data, busy, frame_done, err} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %h expected 0", {mem_wr, mem_addr, mem_data, busy, frame_done, err});
        end
        wb = wr_addr_q.size();
        fb = fd_cnt;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cam_vsync = (i < 3);
            cam_href  = 1'($urandom);
            px_valid  = 1'($urandom);
            px_data   = 12'($urandom);
            tick();
        end
        n_cmp++;
        if (wr_addr_q.size() - wb != 0 || fd_cnt - fb != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_quiet: writes=%0d done=%0d busy=%b expected 0 0 0",
                     wr_addr_q.size() - wb, fd_cnt - fb, busy);
        end
        cam_vsync = 1'b1; cam_href = 1'b0; px_valid = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int wb; int fb; int nw; int bad;
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        arm(1'b0);
        drive_frame(V, -1, 0, 0, -1, 1'b1);
        nw = wr_addr_q.size() - wb;
        n_cmp++;
        if (nw != FR) begin n_bad++; $display("FAIL single_count: got %0d writes expected %0d", nw, FR); end
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (i >= sent_q.size() || wr_addr_q[wb+i] !== AW'(i % FR) ||
                wr_data_q[wb+i] !== sent_q[i] || wr_cyc_q[wb+i] != sent_cyc_q[i])) bad = i;
        n_cmp++;
        if (bad >= 0) begin n_bad++; $display("FAIL single_data: write %0d addr=%0d data=%h wrong", bad, wr_addr_q[wb+bad], wr_data_q[wb+bad]); end
        n_cmp++;
        if (fd_cnt - fb != 1 || err !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_status: done=%0d err=%b busy=%b expected 1 0 0", fd_cnt - fb, err, busy);
        end
    endtask

    task automatic test_continuous();
        int wb; int fb; int nw; int bad;
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        arm(1'b1);
        arm(1'b0);
        drive_frame(V, -1, 0, 0, -1, 1'b1);
        drive_frame(V, -1, 0, 0, -1, 1'b1);
        drive_frame(V, -1, 0, 0, $urandom_range(0, V - 1), 1'b1);
        drive_frame(V, -1, 0, 0, -1, 1'b0);
        nw = wr_addr_q.size() - wb;
        n_cmp++;
        if (nw != 3 * FR) begin n_bad++; $display("FAIL cont_count: got %0d writes expected %0d", nw, 3 * FR); end
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (i >= sent_q.size() || wr_addr_q[wb+i] !== AW'(i % FR) ||
                wr_data_q[wb+i] !== sent_q[i] || wr_cyc_q[wb+i] != sent_cyc_q[i])) bad = i;
        n_cmp++;
        if (bad >= 0) begin n_bad++; $display("FAIL cont_data: write %0d addr=%0d data=%h wrong", bad, wr_addr_q[wb+bad], wr_data_q[wb+bad]); end
        n_cmp++;
        if (fd_cnt - fb != 3 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cont_status: done=%0d busy=%b expected 3 0", fd_cnt - fb, busy);
        end
    endtask

    task automatic test_mid_arm();
        int wb; int fb; int nw; int bad;
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        cam_vsync = 1'b0; cam_href = 1'b1; px_valid = 1'b1; px_data = 12'($urandom);
        arm(1'b0);
        px_valid = 1'b0;
        drive_line(H, 1'b0);
        drive_line(H, 1'b0);
        n_cmp++;
        if (wr_addr_q.size() - wb != 0) begin n_bad++; $display("FAIL midarm_nowrite: got %0d writes expected 0", wr_addr_q.size() - wb); end
        drive_frame(V, -1, 0, 0, -1, 1'b1);
        nw = wr_addr_q.size() - wb;
        n_cmp++;
        if (nw != FR) begin n_bad++; $display("FAIL midarm_count: got %0d writes expected %0d", nw, FR); end
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (i >= sent_q.size() || wr_addr_q[wb+i] !== AW'(i % FR) ||
                wr_data_q[wb+i] !== sent_q[i] || wr_cyc_q[wb+i] != sent_cyc_q[i])) bad = i;
        n_cmp++;
        if (bad >= 0 || fd_cnt - fb != 1) begin n_bad++; $display("FAIL midarm_data: first bad write %0d done=%0d expected -1 1", bad, fd_cnt - fb); end
    endtask

    task automatic test_errors();
        int wb; int fb; int nw; int bad; int nl;
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        arm(1'b0);
        drive_frame(V, -1, 0, 1, -1, 1'b1);
        nw = wr_addr_q.size() - wb;
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== sent_q[i])) bad = i;
        n_cmp++;
        if (nw != FR || bad >= 0) begin n_bad++; $display("FAIL ovf_writes: got %0d writes first bad %0d expected %0d -1", nw, bad, FR); end
        n_cmp++;
        if (err !== 1'b1 || mem_addr !== AW'(FR - 1) || fd_cnt - fb != 1) begin
            n_bad++;
            $display("FAIL ovf_status: err=%b addr=%0d done=%0d expected 1 %0d 1", err, mem_addr, fd_cnt - fb, FR - 1);
        end
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        arm(1'b0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear1: err=%b expected 0", err); end
        nl = $urandom_range(1, V - 1);
        drive_frame(nl, -1, 0, 0, -1, 1'b1);
        nw = wr_addr_q.size() - wb;
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (i >= sent_q.size() || wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== sent_q[i])) bad = i;
        n_cmp++;
        if (nw != nl * H || bad >= 0) begin n_bad++; $display("FAIL short_writes: got %0d writes first bad %0d expected %0d -1", nw, bad, nl * H); end
        n_cmp++;
        if (err !== 1'b1 || fd_cnt - fb != 1) begin n_bad++; $display("FAIL short_status: err=%b done=%0d expected 1 1", err, fd_cnt - fb); end
        fb = fd_cnt;
        arm(1'b0);
        n_cmp++;
        if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear2: err=%b expected 0", err); end
        drive_frame(V, -1, 0, 0, -1, 1'b0);
        n_cmp++;
        if (err !== 1'b0 || fd_cnt - fb != 1) begin n_bad++; $display("FAIL good_after_err: err=%b done=%0d expected 0 1", err, fd_cnt - fb); end
    endtask

    task automatic test_line_check();
        int wb; int fb; int nw; int bad;
        sent_q.delete(); sent_cyc_q.delete();
        wb = wr_addr_q.size(); fb = fd_cnt;
        start = 1'b1; continuous = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; continuous = 1'b0; stop = 1'b0;
        drive_frame(V, $urandom_range(0, V - 2), H - 1, 1, -1, 1'b1);
        nw = wr_addr_q.size() - wb;
        bad = -1;
        for (int i = 0; i < nw; i++)
            if (bad < 0 && (i >= sent_q.size() || wr_addr_q[wb+i] !== AW'(i) || wr_data_q[wb+i] !== sent_q[i])) bad = i;
        n_cmp++;
        if (nw != FR || bad >= 0) begin n_bad++; $display("FAIL line_writes: got %0d writes first bad %0d expected %0d -1", nw, bad, FR); end
        n_cmp++;
        if (err !== LINE_CHECK) begin n_bad++; $display("FAIL line_err: err=%b expected %b", err, LINE_CHECK); end
        drive_frame(V, -1, 0, 0, -1, 1'b0);
        n_cmp++;
        if (wr_addr_q.size() - wb != FR || fd_cnt - fb != 1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_stop_single: writes=%0d done=%0d busy=%b expected %0d 1 0",
                     wr_addr_q.size() - wb, fd_cnt - fb, busy, FR);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_mid_arm();
        test_errors();
        test_line_check();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
